usb_rst_sequencer: RTL and testbench
====================================

Name: usb_rst_sequencer

Overview:
- Avalon-MM slave that replaces the plain USB reset PIO with a hardware-timed reset/bring-up sequencer for the external USB host controller.
- Drives the controller's active-low reset pin for a fixed width, waits a settle time, then waits (with timeout) for the controller's ready/interrupt line.
- Reports done/timeout to the Nios II through a status register and an interrupt.

Parameters:
- ASSERT_CYCLES, 500: clocks `usb_rst_n` is held low per sequence (10 us at 50 MHz).
- SETTLE_CYCLES, 5000: clocks after release before ready is sampled.
- TIMEOUT_CYCLES, 50000: maximum clocks spent waiting for ready.
- CW, 20: width of the shared down-counter. Must hold the largest of the three cycle counts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read mux, zero-extended
- usb_ready  in  1  asynchronous ready/INT from the USB controller, active-high
- usb_rst_n  out  1  registered reset to the USB controller, active-low
- irq  out  1  interrupt to the CPU, active-high

Behaviour:
Clocking and reset:
- One clock `clk`; reset `reset_n` is asynchronous, active-low.
- `usb_ready` passes through a 2-flop synchronizer (`rdy_s`) before use.

Reset values:
- `usb_rst_n` = 0, `irq` = 0, all flags 0, IRQ_EN = 0, COUNT = 0.
- FSM enters ASSERT with counter = ASSERT_CYCLES-1, so power-up auto-sequences.

Register map (a write is `chipselect & ~write_n`):
- addr0 CTRL, write-only. Bit0 GO: starts a sequence, self-clearing. Bit1 FORCE: level, stored. Reads back {30'b0, FORCE, busy}.
- addr1 STATUS. Bit0 busy (RO), bit1 done (W1C), bit2 timeout (W1C), bit3 `rdy_s` (RO).
- addr2 IRQ_EN, R/W. Bit0 enables done, bit1 enables timeout.
- addr3 COUNT, RO. Bits[7:0] = completed sequences, wraps at 255→0. Bits[15:8] = retry count (optional feature only, else 0).

FSM states:
- IDLE: `usb_rst_n` = 1 (0 if FORCE). GO with FORCE=0 → ASSERT next edge; load counter = ASSERT_CYCLES-1.
- ASSERT: `usb_rst_n` = 0. Counter reaches 0 → SETTLE; load SETTLE_CYCLES-1.
- SETTLE: `usb_rst_n` = 1. Counter reaches 0 → WAIT_RDY; load TIMEOUT_CYCLES-1.
- WAIT_RDY: `rdy_s`=1 → IDLE, set done, COUNT++. Otherwise counter reaches 0 → IDLE, set timeout.

Timing and status:
- `usb_rst_n` is low for exactly ASSERT_CYCLES clocks.
- GO written at edge N gives `usb_rst_n`=0 from edge N+1.
- busy = (state != IDLE).
- Counter is a down-counter, reloaded on every state entry, never underflows.

Boundary conditions:
- GO while busy: ignored.
- FORCE=1: aborts the FSM to IDLE immediately and holds `usb_rst_n`=0. No flags are set. GO is ignored while FORCE=1.
- Clearing FORCE returns `usb_rst_n` to 1 next edge. No automatic sequence follows.
- Flag set and W1C on the same edge: set wins.
- `rdy_s`=1 on the same edge the timeout counter expires: done wins.
- `irq` = (done & IRQ_EN[0]) | (timeout & IRQ_EN[1]), registered, 1-cycle latency.
- `reset_n` asserted mid-sequence: everything returns to reset values, then the sequence restarts from ASSERT.

Optional Feature:
- Macro: USB_RST_SEQ_RETRY_EN.
- Defined:
  - Timeout in WAIT_RDY re-enters ASSERT, up to 3 retries. COUNT[15:8] increments per retry.
  - timeout flag is set only after the 3rd retry also times out.
  - The retry counter clears on GO or reset.
- Undefined: the first timeout sets the flag. COUNT[15:8] reads 0.

Test Plan (ASSERT_CYCLES=4, SETTLE_CYCLES=8, TIMEOUT_CYCLES=16):
1. Release `reset_n`, `usb_ready`=1 → `usb_rst_n` low exactly 4 clocks; done=1 about 12 clocks after release plus sync delay; COUNT=1; busy=0.
2. Write IRQ_EN=1, GO, `usb_ready`=0 throughout → timeout=1 after 4+8+16 clocks; `irq` stays 0. Then write IRQ_EN=3 → `irq`=1 next clock. W1C STATUS=0x4 → timeout=0, `irq`=0.
3. GO, then GO again during SETTLE → single sequence only; `usb_rst_n` low for 4 clocks total; COUNT increments by exactly 1.
4. GO, then CTRL=0x2 during ASSERT → busy=0 next clock, `usb_rst_n` held 0, no flags set. Then CTRL=0 → `usb_rst_n`=1 next clock, FSM idle.
5. Pulse `reset_n` low during WAIT_RDY → `usb_rst_n`=0 immediately, flags/COUNT=0, sequence restarts.
6. (USB_RST_SEQ_RETRY_EN) `usb_ready`=0 → 4 ASSERT pulses observed, COUNT[15:8]=3, then timeout=1.

Source files
------------

// File: rtl/usb_rst_sequencer_if.sv
// Avalon-MM slave bus for the USB reset sequencer register file.
interface usb_rst_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/usb_rst_sequencer.sv
// Hardware-timed reset / bring-up sequencer for an external USB host
// controller. Holds usb_rst_n low for ASSERT_CYCLES, waits SETTLE_CYCLES,
// then waits up to TIMEOUT_CYCLES for the (synchronized) ready line and
// reports done/timeout through STATUS and irq.
// Optional feature macro: USB_RST_SEQ_RETRY_EN (re-run the reset up to
// 3 more times on a ready timeout; retries visible in COUNT[15:8]).
module usb_rst_sequencer #(
    parameter int ASSERT_CYCLES  = 500,
    parameter int SETTLE_CYCLES  = 5000,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CW             = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    usb_rst_sequencer_if.slave   bus,
    input  logic                 usb_ready,
    output logic                 usb_rst_n,
    output logic                 irq
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        SETTLE   = 2'd2,
        WAIT_RDY = 2'd3
    } state_t;

    localparam logic [CW-1:0] A_LD = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] S_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] T_LD = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rdy_meta, rdy_s;
    logic          force_q, done_q, tmo_q;
    logic [1:0]    irq_en;
    logic [7:0]    seq_cnt;
    logic [7:0]    retry_q;
    logic          retry_more;

    logic wr, wr_ctrl, wr_stat, wr_irqen;
    logic busy, abort, go_ok, rdy_hit, tmo_fire, done_set, tmo_set;
    logic unused_wdata;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign wr_ctrl  = wr & (bus.address == 2'd0);
    assign wr_stat  = wr & (bus.address == 2'd1);
    assign wr_irqen = wr & (bus.address == 2'd2);

    assign busy     = (state != IDLE);
    // FORCE takes effect on the very edge it is written, not a cycle later.
    assign abort    = (wr_ctrl & bus.writedata[1]) | force_q;
    assign go_ok    = wr_ctrl & bus.writedata[0] & ~abort & ~busy;
    assign rdy_hit  = (state == WAIT_RDY) & rdy_s;
    // Ready on the expiry edge counts as success, so rdy_s gates the timeout.
    assign tmo_fire = (state == WAIT_RDY) & ~rdy_s & (cnt == '0);
    assign done_set = rdy_hit & ~abort;
    assign tmo_set  = tmo_fire & ~retry_more & ~abort;

    assign unused_wdata = ^bus.writedata[31:2];

    // Two-flop synchronizer for the asynchronous ready/INT line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= usb_ready;
            rdy_s    <= rdy_meta;
        end
    end

    // Sequencer FSM: counter reloads on each state entry; reset starts a sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ASSERT;
            cnt       <= A_LD;
            usb_rst_n <= 1'b0;
        end else begin
            usb_rst_n <= ~(force_q | (state == ASSERT));
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go_ok) begin
                            state <= ASSERT;
                            cnt   <= A_LD;
                        end
                    end
                    ASSERT: begin
                        if (cnt == '0) begin
                            state <= SETTLE;
                            cnt   <= S_LD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            state <= WAIT_RDY;
                            cnt   <= T_LD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    WAIT_RDY: begin
                        if (rdy_s) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == '0) begin
                            if (retry_more) begin
                                state <= ASSERT;
                                cnt   <= A_LD;
                            end else begin
                                state <= IDLE;
                                cnt   <= '0;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef USB_RST_SEQ_RETRY_EN
    assign retry_more = (retry_q < 8'd3);

    // Retry counter: cleared by an accepted GO, bumped on each re-entry to ASSERT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            retry_q <= 8'd0;
        else if (go_ok)
            retry_q <= 8'd0;
        else if (tmo_fire & retry_more & ~abort)
            retry_q <= retry_q + 8'd1;
    end
`else
    assign retry_more = 1'b0;
    assign retry_q    = 8'd0;
`endif

    // Control/status registers; a flag set beats a same-edge W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            force_q <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            irq_en  <= 2'b00;
            seq_cnt <= 8'd0;
        end else begin
            if (wr_ctrl)
                force_q <= bus.writedata[1];
            if (wr_irqen)
                irq_en <= bus.writedata[1:0];
            done_q <= done_set | (done_q & ~(wr_stat & bus.writedata[1]));
            tmo_q  <= tmo_set  | (tmo_q  & ~(wr_stat & bus.writedata[2]));
            if (done_set)
                seq_cnt <= seq_cnt + 8'd1;
        end
    end

    // Interrupt is registered from the flags, one cycle behind them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= (done_q & irq_en[0]) | (tmo_q & irq_en[1]);
    end

    // Combinational read mux, zero-extended.
    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0: bus.readdata = {30'd0, force_q, busy};
            2'd1: bus.readdata = {28'd0, rdy_s, tmo_q, done_q, busy};
            2'd2: bus.readdata = {30'd0, irq_en};
            2'd3: bus.readdata = {16'd0, retry_q, seq_cnt};
            default: bus.readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Self-checking bench for usb_rst_sequencer with small cycle counts.
// The reference model predicts, from the ready-rise cycle alone, when the
// sequence ends, whether it ends in done or timeout, and how many retries
// and reset pulses it takes.
module tb_usb_rst_sequencer;
    localparam int A = 4;
    localparam int S = 8;
    localparam int T = 16;
    localparam int P = A + S + T;
`ifdef USB_RST_SEQ_RETRY_EN
    localparam int ATT = 4;
`else
    localparam int ATT = 1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic usb_ready = 1'b0;
    logic usb_rst_n;
    logic irq;

    usb_rst_sequencer_if bus ();

    usb_rst_sequencer #(
        .ASSERT_CYCLES (A),
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T),
        .CW            (20)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .usb_ready(usb_ready),
        .usb_rst_n(usb_rst_n),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int seq_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-cycle write; returns #1 after the edge that samples it.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
        bus.address = 2'd1;
    endtask

    // Model: sequence starts at edge 0; ready rises after edge d (d<0: already
    // high), so it is first usable at edge d+3. Attempt i waits on edges
    // i*P+A+S+1 .. i*P+P.
    function automatic void model(input int d, output int end_c, output bit dn, output int rtr);
        bit found = 0;
        end_c = ATT * P; dn = 0; rtr = ATT - 1;
        for (int i = 0; i < ATT; i++) begin
            int e;
            e = i * P + A + S + 1;
            if (d + 3 > e) e = d + 3;
            if (!found && e <= i * P + P) begin
                found = 1; end_c = e; dn = 1; rtr = i;
            end
        end
    endfunction

    // Follow one sequence cycle by cycle from edge 0 until busy drops.
    task automatic measure(input int d, input int wc, input logic [1:0] wa, input logic [31:0] wd,
                           output int end_c, output int lows);
        int cyc = 0;
        bit fin = 0;
        end_c = -1; lows = 0;
        while (!fin && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd1;
            #1;
            if (usb_rst_n === 1'b0) lows++;
            if (bus.readdata[0] === 1'b0) begin end_c = cyc; fin = 1; end
            if (cyc == d) usb_ready = 1'b1;
            if (cyc == wc && !fin) begin
                bus.address = wa; bus.writedata = wd; bus.chipselect = 1'b1; bus.write_n = 1'b0;
            end
        end
    endtask

    // Compare a finished sequence against the model; ends one cycle later for irq.
    task automatic post_checks(input string tag, input int d, input logic [1:0] en,
                               input int end_c, input int lows);
        int   e_end, rtr;
        bit   dn;
        logic [31:0] rd;
        model(d, e_end, dn, rtr);
        if (dn) seq_cnt = (seq_cnt + 1) % 256;
        check({tag, "_end"}, end_c, e_end);
        check({tag, "_lows"}, lows, (rtr + 1) * A);
        bus_read(2'd1, rd);
        check({tag, "_status"}, {29'd0, rd[2:0]}, {29'd0, ~dn, dn, 1'b0});
        bus_read(2'd3, rd);
        check({tag, "_count"}, rd, {16'd0, 8'(rtr), 8'(seq_cnt)});
        @(posedge clk);
        @(negedge clk);
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, (dn & en[0]) | (~dn & en[1])});
    endtask

    task automatic run_seq(input string tag, input int d, input logic [1:0] en,
                           input int wc, input logic [31:0] wd);
        int end_c, lows;
        bus_write(2'd1, 32'h6);
        bus_write(2'd2, {30'd0, en});
        usb_ready = (d < 0);
        repeat (3) @(negedge clk);
        bus_write(2'd0, 32'h1);
        measure(d, wc, 2'd0, wd, end_c, lows);
        post_checks(tag, d, en, end_c, lows);
    endtask

    initial begin
        logic [31:0] rd;
        int end_c, lows, c;
        bus.address = 2'd1; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;

        // 1. Reset state, then power-up auto-sequence with ready high.
        usb_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_usb_rst_n", {31'd0, usb_rst_n}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        bus_read(2'd1, rd); check("rst_status", rd, 32'h1);
        bus_read(2'd2, rd); check("rst_irq_en", rd, 32'h0);
        bus_read(2'd3, rd); check("rst_count", rd, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        measure(-1, -1, 2'd0, 32'd0, end_c, lows);
        post_checks("pwrup", -1, 2'b00, end_c, lows);

        // 2. Timeout with only the done interrupt enabled, then enable and clear.
        run_seq("tmo", 1000, 2'b01, -1, 32'd0);
        bus_write(2'd2, 32'h3);
        check("irq_lat0", {31'd0, irq}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("irq_lat1", {31'd0, irq}, 32'd1);
        bus_write(2'd1, 32'h4);
        @(negedge clk);
        bus_read(2'd1, rd); check("tmo_w1c", {31'd0, rd[2]}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("irq_clear", {31'd0, irq}, 32'd0);

        // 3. Second GO during SETTLE is ignored.
        run_seq("go_busy", -1, 2'b01, $urandom_range(A, A + S - 1), 32'h1);

        // 4. FORCE during ASSERT aborts and holds reset; clearing it releases.
        bus_write(2'd1, 32'h6);
        usb_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus_write(2'd0, 32'h1);
        c = $urandom_range(1, A - 1);
        measure(-1, c, 2'd0, 32'h2, end_c, lows);
        check("force_end", end_c, c + 1);
        check("force_lows", lows, c + 1);
        repeat (5) @(negedge clk);
        check("force_hold", {31'd0, usb_rst_n}, 32'd0);
        bus_read(2'd1, rd); check("force_status", {29'd0, rd[2:0]}, 32'd0);
        bus_read(2'd0, rd); check("force_ctrl", rd, 32'h2);
        bus_read(2'd3, rd); check("force_count", rd, {16'd0, 8'd0, 8'(seq_cnt)});
        bus_write(2'd0, 32'h0);
        check("unforce_lat0", {31'd0, usb_rst_n}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("unforce_lat1", {31'd0, usb_rst_n}, 32'd1);
        repeat (5) @(negedge clk);
        bus_read(2'd0, rd); check("unforce_idle", rd, 32'h0);
        check("unforce_hold", {31'd0, usb_rst_n}, 32'd1);

        // 5. Reset pulse during WAIT_RDY restarts everything.
        bus_write(2'd1, 32'h6);
        usb_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus_write(2'd0, 32'h1);
        repeat (A + S + 3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_usb_rst_n", {31'd0, usb_rst_n}, 32'd0);
        bus_read(2'd1, rd); check("midrst_status", rd, 32'h1);
        bus_read(2'd3, rd); check("midrst_count", rd, 32'h0);
        seq_cnt = 0;
        usb_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        measure(-1, -1, 2'd0, 32'd0, end_c, lows);
        post_checks("restart", -1, 2'b00, end_c, lows);

        // 6. Ready on the last wait edge (done wins) and one edge too late.
        run_seq("edge_done", A + S + T - 3, 2'b11, -1, 32'd0);
        run_seq("edge_late", A + S + T - 2, 2'b10, -1, 32'd0);

        // 7. Randomized ready timing and interrupt enables.
        for (int i = 0; i < 8; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, ATT * P + 4));
            run_seq("rand", d, 2'($urandom_range(0, 3)), -1, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
